spi_slave: RTL and testbench
============================

# spi_slave

SPI slave endpoint that pairs with the team's SPI master on the same four-wire bus. It oversamples SCK, SSN and MOSI in the system clock domain and supports all four CPOL/CPHA modes. Bytes are exchanged MSB-first through a one-byte transmit buffer and a one-byte receive buffer with status flags. It sits between the external SPI pins and the local register/CPU interface.

## Interface
- SYNC_STAGES, 2, number of flops in each input synchronizer for sck/ssn/mosi (≥2)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- spcon  input  8  control: [0] spen, [1] cpha, [2] cpol, [7:3] ignored
- sck  input  1  SPI clock from master
- ssn  input  1  slave select, active-low
- mosi  input  1  master-out data
- miso  output  1  slave-out data; reset 0
- tx_data  input  8  byte to transmit
- tx_load  input  1  write tx_data into tx buffer
- tx_empty  output  1  tx buffer free; reset 1
- rx_data  output  8  last received byte; reset 8'h00
- rx_full  output  1  unread byte in rx_data; reset 0
- rx_rd  input  1  acknowledge/read of rx_data
- ovr  output  1  sticky overrun flag; reset 0
- busy  output  1  frame active (synchronized ssn low and spen); reset 0

## Operation
- sck, ssn, mosi each pass through SYNC_STAGES flops, then one extra flop for edge detection; all logic uses the synchronized versions.
- Leading edge = sck leaving idle level cpol; trailing edge = return to cpol.
- cpha=0: sample mosi on leading edges, shift miso on trailing edges; the MSB is driven on miso at frame start.
- cpha=1: shift miso on leading edges (the first leading edge drives the MSB); sample mosi on trailing edges.
- Frame start (synchronized ssn falling while spen=1): bit_cnt←0; shift_tx←tx_buf if tx_empty=0, else 8'h00; tx_empty←1.
- Each sample: shift_rx←{shift_rx[6:0], mosi}, bit_cnt+1 (3-bit, wraps 7→0).
- 8th sample: rx_data←completed byte, rx_full←1. If rx_full was already 1, also set ovr←1; the new byte overwrites rx_data. If ssn is still low, the next byte begins immediately: shift_tx reloads from tx_buf (or 8'h00) and tx_empty←1. For cpha=0 the new MSB appears on miso on the trailing edge that follows.
- tx_load with tx_empty=1: tx_buf←tx_data, tx_empty←0. tx_load with tx_empty=0 is ignored.
- rx_rd: rx_full←0, ovr←0. If rx_rd coincides with a byte completion, completion wins: rx_full=1, and ovr is set only if rx_full was 1 before this cycle.
- Synchronized ssn rising mid-byte: abort. bit_cnt←0, partial byte discarded, no rx_full change, miso←0.
- miso=0 whenever synchronized ssn=1 or spen=0 (board gates drive with ssn).
- spen=0: sck/ssn edges ignored, busy=0, bit_cnt←0. Buffers and flags are retained.
- Reset mid-frame: all outputs take their reset values immediately. The slave rejoins only on the next ssn falling edge after spen=1.

## Timing
- Pin edge to internal action: SYNC_STAGES+1 clk cycles; miso change follows a shifting sck edge by SYNC_STAGES+2 cycles.
- Requirement on master: sck high and low phases each ≥ 2·SYNC_STAGES+2 clk cycles. With the default this means spibr ≥ 5 when both blocks share clk.
- cpha=0: ssn fall to first sck edge ≥ SYNC_STAGES+3 clk cycles.
- rx_full rises SYNC_STAGES+2 cycles after the 8th sampling sck edge at the pin.
- tx_empty rises on the cycle the byte is loaded into shift_tx.
- tx_load/rx_rd take effect on the next clk edge.

## Test plan
- Mode 0 (cpol=0, cpha=0), tx_buf=8'hA5, master sends 8'h3C -> miso carries 10100101, rx_data=8'h3C, rx_full=1, ovr=0.
- Each of modes 1, 2 and 3 with tx 8'h81 / rx 8'h7E -> correct bytes both directions; miso changes only on the mode's shift edge.
- Two back-to-back bytes under one ssn, no rx_rd between, tx buffer reloaded after the first -> second byte in rx_data, ovr=1; rx_rd then clears rx_full and ovr.
- tx buffer empty at frame start -> miso all zeros, rx still received; tx_load while tx_empty=0 is ignored (tx_buf unchanged).
- ssn raised after 4 bits, then a full new frame with 8'hC3 -> no rx_full from the aborted frame; rx_data=8'hC3 after the new frame.
- Async reset asserted mid-byte, and spen=0 during a frame -> outputs at reset values / edges ignored; a subsequent clean frame transfers correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled sck/ssn/mosi, all four CPOL/CPHA modes,
// MSB-first byte exchange through one-byte tx/rx buffers with status flags.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spcon,
    input  logic       sck,
    input  logic       ssn,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic [7:0] rx_data,
    output logic       rx_full,
    input  logic       rx_rd,
    output logic       ovr,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ssn_sync, r_mosi_sync;
    logic                   r_sck_d, r_ssn_d;
    logic [0:0]             r_state, w_state_nxt;
    logic [CW-1:0]          r_bit_cnt;
    logic [DW-1:0]          r_shift_tx, r_shift_rx, r_tx_buf, r_rx_data;
    logic                   r_tx_bit, r_done, r_miso, r_tx_empty, r_rx_full, r_ovr;

    logic w_spen, w_cpha, w_cpol, w_unused;
    logic w_sck_s, w_ssn_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_ssn_rise, w_ssn_fall;
    logic w_lead, w_trail, w_sample, w_shift;
    logic w_frame_start, w_abort, w_complete, w_active;
    logic [DW-1:0] w_ld, w_rx_byte;

    assign w_spen   = spcon[0];
    assign w_cpha   = spcon[1];
    assign w_cpol   = spcon[2];
    assign w_unused = ^spcon[7:3];

    // Input synchronizers plus one edge-detect flop; ssn chain resets low so a
    // slave held selected across reset needs a fresh ssn fall to rejoin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_ssn_sync  <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ssn_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_ssn_d     <= r_ssn_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_ssn_s    = r_ssn_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_ssn_rise = w_ssn_s & ~r_ssn_d;
    assign w_ssn_fall = ~w_ssn_s & r_ssn_d;
    assign w_lead     = w_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail    = w_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample   = w_cpha ? w_trail : w_lead;
    assign w_shift    = w_cpha ? w_lead : w_trail;

    assign w_active      = (r_state == S_ACTIVE);
    assign w_frame_start = (r_state == S_IDLE) & w_ssn_fall & w_spen;
    assign w_abort       = w_active & (w_ssn_rise | ~w_spen);
    assign w_complete    = w_active & ~w_abort & w_sample & (r_bit_cnt == 3'd7);
    assign w_ld          = r_tx_empty ? 8'h00 : r_tx_buf;
    assign w_rx_byte     = {r_shift_rx[DW-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_frame_start) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_abort) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Shift datapath, buffers and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_tx_buf   <= '0;
            r_rx_data  <= '0;
            r_tx_bit   <= 1'b0;
            r_done     <= 1'b0;
            r_miso     <= 1'b0;
            r_tx_empty <= 1'b1;
            r_rx_full  <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A completing byte beats a simultaneous rx_rd
            if (r_done) begin
                r_rx_data <= r_shift_rx;
                r_rx_full <= 1'b1;
                r_ovr     <= r_rx_full | (r_ovr & ~rx_rd);
            end else if (rx_rd) begin
                r_rx_full <= 1'b0;
                r_ovr     <= 1'b0;
            end

            if (!w_spen) r_bit_cnt <= '0;

            if (w_frame_start) begin
                r_bit_cnt  <= '0;
                r_shift_tx <= w_cpha ? w_ld : {w_ld[DW-2:0], 1'b0};
                r_tx_bit   <= w_cpha ? 1'b0 : w_ld[DW-1];
            end else if (w_abort) begin
                r_bit_cnt <= '0;
                r_tx_bit  <= 1'b0;
            end else if (w_active) begin
                if (w_sample) begin
                    r_shift_rx <= w_rx_byte;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_complete) begin
                    r_done     <= 1'b1;
                    r_shift_tx <= w_ld;
                end
                if (w_shift) begin
                    r_tx_bit   <= r_shift_tx[DW-1];
                    r_shift_tx <= {r_shift_tx[DW-2:0], 1'b0};
                end
            end

            if (w_frame_start || w_complete) r_tx_empty <= 1'b1;
            if (tx_load && r_tx_empty) begin
                r_tx_buf   <= tx_data;
                r_tx_empty <= 1'b0;
            end

            r_miso <= (w_active && !w_abort) ? r_tx_bit : 1'b0;
        end
    end

    assign miso     = r_miso;
    assign tx_empty = r_tx_empty;
    assign rx_data  = r_rx_data;
    assign rx_full  = r_rx_full;
    assign ovr      = r_ovr;
    assign busy     = r_state[0];

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, byte-level reference model and
// an rx scoreboard popped by a monitor on each rx_full/ovr rise.
module tb_spi_slave;

    localparam int H     = 8;
    localparam int SETUP = 10;
    localparam int GAP   = 12;

    logic       clk, rst_n, sck, ssn, mosi, miso;
    logic [7:0] spcon, tx_data, rx_data;
    logic       tx_load, tx_empty, rx_full, rx_rd, ovr, busy;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spcon(spcon), .sck(sck), .ssn(ssn),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
        .tx_empty(tx_empty), .rx_data(rx_data), .rx_full(rx_full),
        .rx_rd(rx_rd), .ovr(ovr), .busy(busy)
    );

    typedef struct packed { logic [7:0] data; logic ovr; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    logic       cur_cpol, cur_cpha;
    logic [7:0] m_tx_buf, m_cur_tx;
    logic       m_tx_empty, m_rx_full, m_ovr;
    logic       mon_full_q, mon_ovr_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every received byte shows up as a rise of rx_full, or of ovr when unread
    always @(negedge clk) begin
        if (rst_n && ((rx_full && !mon_full_q) || (ovr && !mon_ovr_q))) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rx: got rx_data %0h expected no byte", rx_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(mon_e.data));
                chk("rx_ovr", 32'(ovr), 32'(mon_e.ovr));
            end
        end
        mon_full_q <= rx_full;
        mon_ovr_q  <= ovr;
    end

    task automatic set_mode(input logic pol, input logic pha, input logic en);
        cur_cpol = pol;
        cur_cpha = pha;
        spcon    = {5'b0, pol, pha, en};
        sck      = pol;
        cyc(6);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        if (m_tx_empty) begin
            m_tx_buf   = v;
            m_tx_empty = 1'b0;
        end
        chk("tx_empty_after_load", 32'(tx_empty), 32'(m_tx_empty));
    endtask

    task automatic rd();
        rx_rd = 1'b1;
        cyc(1);
        rx_rd     = 1'b0;
        m_rx_full = 1'b0;
        m_ovr     = 1'b0;
        chk("rx_full_after_rd", 32'(rx_full), 32'(0));
        chk("ovr_after_rd", 32'(ovr), 32'(0));
    endtask

    task automatic frame_begin();
        ssn = 1'b0;
        cyc(SETUP);
        m_cur_tx   = m_tx_empty ? 8'h00 : m_tx_buf;
        m_tx_empty = 1'b1;
        chk("busy_in_frame", 32'(busy), 32'(1));
        chk("tx_empty_frame_start", 32'(tx_empty), 32'(1));
    endtask

    task automatic frame_end();
        cyc(H);
        ssn = 1'b1;
        cyc(GAP);
        chk("busy_after_frame", 32'(busy), 32'(0));
    endtask

    // Shift nbits on the bus; a full byte is scored on both directions
    task automatic xfer(input logic [7:0] mo, input int nbits);
        logic [7:0] mi;
        mi = 8'h00;
        if (nbits == 8) begin
            sb_q.push_back('{data: mo, ovr: (m_ovr | m_rx_full)});
            m_ovr     = m_ovr | m_rx_full;
            m_rx_full = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            if (!cur_cpha) begin
                mosi = mo[7-i];
                cyc(H);
                mi  = {mi[6:0], miso};
                sck = ~cur_cpol;
                cyc(H);
                sck = cur_cpol;
            end else begin
                sck  = ~cur_cpol;
                mosi = mo[7-i];
                cyc(H);
                mi  = {mi[6:0], miso};
                sck = cur_cpol;
                cyc(H);
            end
        end
        if (nbits == 8) begin
            chk("miso_byte", 32'(mi), 32'(m_cur_tx));
            m_cur_tx   = m_tx_empty ? 8'h00 : m_tx_buf;
            m_tx_empty = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [7:0] mo);
        frame_begin();
        xfer(mo, 8);
        frame_end();
        chk("rx_full_after_frame", 32'(rx_full), 32'(m_rx_full));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miso", 32'(miso), 32'(0));
        chk("rst_tx_empty", 32'(tx_empty), 32'(1));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_rx_full", 32'(rx_full), 32'(0));
        chk("rst_ovr", 32'(ovr), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    task automatic model_reset();
        m_tx_empty = 1'b1;
        m_tx_buf   = 8'h00;
        m_cur_tx   = 8'h00;
        m_rx_full  = 1'b0;
        m_ovr      = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; spcon = 8'h00; sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0; rx_rd = 1'b0;
        cur_cpol = 1'b0; cur_cpha = 1'b0;
        model_reset();
        cyc(3);
        chk_reset_outputs();
        rst_n = 1'b1;
        cyc(3);

        // Mode 0 basic exchange
        set_mode(1'b0, 1'b0, 1'b1);
        load(8'hA5);
        do_frame(8'h3C);
        chk("ovr_mode0", 32'(ovr), 32'(0));
        rd();

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            load(8'h81);
            do_frame(8'h7E);
            rd();
        end

        // Two bytes under one ssn, buffer refilled after frame start, no read between
        set_mode(1'b0, 1'b0, 1'b1);
        load(8'h11);
        frame_begin();
        load(8'h22);
        xfer(8'h55, 8);
        xfer(8'hAA, 8);
        frame_end();
        chk("b2b_rx_full", 32'(rx_full), 32'(1));
        chk("b2b_ovr", 32'(ovr), 32'(1));
        chk("b2b_rx_data", 32'(rx_data), 32'(8'hAA));
        rd();

        // Empty tx buffer sends zeros; second load while full is dropped
        do_frame(8'h96);
        rd();
        load(8'h5A);
        load(8'hC7);
        do_frame(8'h0F);
        rd();

        // Abort after four bits, then a clean frame
        set_mode(1'b0, 1'b1, 1'b1);
        load(8'hE1);
        frame_begin();
        xfer(8'hFF, 4);
        frame_end();
        chk("abort_rx_full", 32'(rx_full), 32'(0));
        do_frame(8'hC3);
        chk("post_abort_rx_data", 32'(rx_data), 32'(8'hC3));
        rd();

        // Async reset mid-byte; slave stays out until a fresh ssn fall
        set_mode(1'b1, 1'b1, 1'b1);
        load(8'h99);
        frame_begin();
        xfer(8'h12, 4);
        rst_n = 1'b0;
        cyc(2);
        chk_reset_outputs();
        model_reset();
        rst_n = 1'b1;
        cyc(2);
        xfer(8'h34, 4);
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_miso", 32'(miso), 32'(0));
        frame_end();
        load(8'hB4);
        do_frame(8'h4B);
        rd();

        // spen dropped mid-frame: edges ignored, then a clean frame
        set_mode(1'b1, 1'b0, 1'b1);
        load(8'h6D);
        frame_begin();
        xfer(8'hF0, 3);
        spcon = {5'b0, cur_cpol, cur_cpha, 1'b0};
        cyc(4);
        chk("spen0_busy", 32'(busy), 32'(0));
        chk("spen0_miso", 32'(miso), 32'(0));
        xfer(8'h0F, 5);
        frame_end();
        chk("spen0_rx_full", 32'(rx_full), 32'(0));
        spcon = {5'b0, cur_cpol, cur_cpha, 1'b1};
        cyc(4);
        load(8'h3E);
        do_frame(8'hD2);
        rd();

        // Randomized frames across modes
        for (int k = 0; k < 12; k++) begin
            logic [1:0] md;
            logic [7:0] tv, mv;
            md = 2'($urandom_range(0, 3));
            tv = 8'($urandom);
            mv = 8'($urandom);
            set_mode(md[1], md[0], 1'b1);
            if ($urandom_range(0, 3) != 0) load(tv);
            do_frame(mv);
            rd();
        end

        cyc(10);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
